// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with clock-enable prescaler, synchronous load/clear,
// wrap or saturate at the bounds, and a registered one-cycle terminal-count pulse.
module mod_updown_counter #(
    parameter int WIDTH     = 12,
    parameter int MAX_COUNT = 4095,
    parameter int PRESCALE  = 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [WIDTH-1:0] MAX_C    = MAX_COUNT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_C   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C    = WIDTH'(1);
    localparam logic [PW-1:0]    PRE_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_r;
    logic [PW-1:0]    pre_r;
    logic             tc_r;

    logic [WIDTH-1:0] count_nxt_s;
    logic [PW-1:0]    pre_nxt_s;
    logic             tc_nxt_s;
    logic [WIDTH-1:0] load_clamp_s;

    // Clamp the load value so count can never be placed above MAX_COUNT.
    always_comb begin
        if (load_val > MAX_C) begin
            load_clamp_s = MAX_C;
        end else begin
            load_clamp_s = load_val;
        end
    end

    // Next-state: clear > load > prescaled step > hold; bounds handled by compare.
    always_comb begin
        count_nxt_s = count_r;
        pre_nxt_s   = pre_r;
        tc_nxt_s    = 1'b0;
        if (clear) begin
            count_nxt_s = ZERO_C;
            pre_nxt_s   = PRE_ZERO;
        end else if (load) begin
            count_nxt_s = load_clamp_s;
            pre_nxt_s   = PRE_ZERO;
        end else if (en) begin
            if (pre_r == PRE_LAST) begin
                pre_nxt_s = PRE_ZERO;
                if (up) begin
                    if (count_r == MAX_C) begin
                        tc_nxt_s = 1'b1;
                        if (SATURATE != 0) begin
                            count_nxt_s = MAX_C;
                        end else begin
                            count_nxt_s = ZERO_C;
                        end
                    end else begin
                        count_nxt_s = count_r + ONE_C;
                    end
                end else begin
                    if (count_r == ZERO_C) begin
                        tc_nxt_s = 1'b1;
                        if (SATURATE != 0) begin
                            count_nxt_s = ZERO_C;
                        end else begin
                            count_nxt_s = MAX_C;
                        end
                    end else begin
                        count_nxt_s = count_r - ONE_C;
                    end
                end
            end else begin
                pre_nxt_s = pre_r + PRE_ONE;
            end
        end else begin
            pre_nxt_s = pre_r;
        end
    end

    // State registers; reset discards any prescaler phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= ZERO_C;
            pre_r   <= PRE_ZERO;
            tc_r    <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            pre_r   <= pre_nxt_s;
            tc_r    <= tc_nxt_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: five counter configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model, plus directed spot checks.
module tb_mod_updown_counter;

    localparam int NI = 5;
    localparam int CFG_W   [NI] = '{12, 12, 4, 4, 12};
    localparam int CFG_MAX [NI] = '{4095, 4095, 9, 9, 999};
    localparam int CFG_PRE [NI] = '{1, 4, 1, 1, 1};
    localparam int CFG_SAT [NI] = '{0, 0, 0, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n, en, up, clear, load;
    logic [11:0] load_val;
    logic [11:0] c0, c1, c4;
    logic [3:0]  c2, c3;
    logic        t0, t1, t2, t3, t4;

    int m_cnt [NI];
    int m_pre [NI];
    int m_tc  [NI];
    int n_vec = 0;
    int n_err = 0;
    int exp_c [4];
    int exp_t [4];

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(12), .MAX_COUNT(4095), .PRESCALE(1), .SATURATE(0)) d0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .count(c0), .tc(t0));
    mod_updown_counter #(.WIDTH(12), .MAX_COUNT(4095), .PRESCALE(4), .SATURATE(0)) d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .count(c1), .tc(t1));
    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(0)) d2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .count(c2), .tc(t2));
    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1)) d3 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .count(c3), .tc(t3));
    mod_updown_counter #(.WIDTH(12), .MAX_COUNT(999), .PRESCALE(1), .SATURATE(0)) d4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .count(c4), .tc(t4));

    function automatic int dut_cnt(int i);
        case (i)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            3: return int'(c3);
            4: return int'(c4);
            default: return -1;
        endcase
    endfunction

    function automatic int dut_tc(int i);
        case (i)
            0: return int'(t0);
            1: return int'(t1);
            2: return int'(t2);
            3: return int'(t3);
            4: return int'(t4);
            default: return -1;
        endcase
    endfunction

    task automatic check(string tag, int idx, int obs, int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    // Reference: prescaler is a modulo-PRESCALE phase; a step moves count on the
    // ring 0..MAX (wrap) or clamps to [0, MAX] (saturate).
    task automatic model_edge();
        int mx, lv, nxt;
        for (int i = 0; i < NI; i++) begin
            mx = CFG_MAX[i];
            m_tc[i] = 0;
            if (!rst_n || clear) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
            end else if (load) begin
                lv = int'(load_val) % (1 << CFG_W[i]);
                m_cnt[i] = (lv > mx) ? mx : lv;
                m_pre[i] = 0;
            end else if (en) begin
                m_pre[i] = (m_pre[i] + 1) % CFG_PRE[i];
                if (m_pre[i] == 0) begin
                    nxt = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    m_tc[i] = (nxt > mx || nxt < 0) ? 1 : 0;
                    if (CFG_SAT[i] != 0)
                        m_cnt[i] = (nxt > mx) ? mx : ((nxt < 0) ? 0 : nxt);
                    else
                        m_cnt[i] = (nxt + mx + 1) % (mx + 1);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NI; i++) begin
            check("count_vs_model", i, dut_cnt(i), m_cnt[i]);
            check("tc_vs_model", i, dut_tc(i), m_tc[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 12'd0;
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
        end

        // Reset held three clocks with en high
        repeat (3) tick();
        check("reset_count", 0, int'(c0), 0);
        check("reset_tc", 0, int'(t0), 0);

        // Free run up through the 4095 -> 0 wrap; PRESCALE=4 instance alongside
        rst_n = 1'b1;
        for (int i = 1; i <= 4096; i++) begin
            tick();
            if (i == 1)    check("first_step", 0, int'(c0), 1);
            if (i == 4)    check("pre4_first", 1, int'(c1), 1);
            if (i == 40)   check("pre4_forty", 1, int'(c1), 10);
            if (i == 4095) begin
                check("at_max", 0, int'(c0), 4095);
                check("at_max_tc", 0, int'(t0), 0);
            end
            if (i == 4096) begin
                check("wrap_count", 0, int'(c0), 0);
                check("wrap_tc", 0, int'(t0), 1);
            end
        end
        tick();
        check("tc_one_cycle", 0, int'(t0), 0);

        // Enable gap at prescaler phase 2
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (2) tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_gap_hold", 1, int'(c1), 0);
        end
        en = 1'b1;
        tick(); check("en_back_1", 1, int'(c1), 0);
        tick(); check("en_back_2", 1, int'(c1), 1);

        // MAX=9 wrap counting down from 2
        load_val = 12'd2; load = 1'b1; tick(); load = 1'b0;
        check("load2", 2, int'(c2), 2);
        up = 1'b0;
        exp_c = '{1, 0, 9, 8};
        exp_t = '{0, 0, 1, 0};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("down_wrap_cnt", 2, int'(c2), exp_c[i]);
            check("down_wrap_tc", 2, int'(t2), exp_t[i]);
        end

        // MAX=9 saturate counting up from 8
        load_val = 12'd8; load = 1'b1; tick(); load = 1'b0;
        up = 1'b1;
        exp_c = '{9, 9, 9, 9};
        exp_t = '{0, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sat_cnt", 3, int'(c3), exp_c[i]);
            check("sat_tc", 3, int'(t3), exp_t[i]);
        end
        up = 1'b0;
        tick();
        check("sat_leave_cnt", 3, int'(c3), 8);
        check("sat_leave_tc", 3, int'(t3), 0);

        // Load clamping, then clear+load on a would-be boundary step
        load_val = 12'd4000; load = 1'b1; tick();
        check("load_clamp", 4, int'(c4), 999);
        check("load_noclamp", 0, int'(c0), 4000);
        clear = 1'b1; up = 1'b1; en = 1'b1; tick();
        check("clear_prio_cnt", 4, int'(c4), 0);
        check("clear_prio_tc", 4, int'(t4), 0);
        clear = 1'b0; load = 1'b0;

        // Reset mid-prescale discards the phase
        load_val = 12'd5; load = 1'b1; tick(); load = 1'b0;
        repeat (3) tick();
        check("pre3_cnt", 1, int'(c1), 5);
        rst_n = 1'b0; tick();
        check("midreset_cnt", 1, int'(c1), 0);
        check("midreset_tc", 1, int'(t1), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_reset_wait", 1, int'(c1), 0);
        end
        tick();
        check("post_reset_step", 1, int'(c1), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst_n    = ($urandom_range(0, 99) != 0);
            clear    = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = 12'($urandom);
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 1) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
